// File: rtl/timer.sv
// Timer block: 16-bit free-running divider, TIMA/TMA/TAC registers and the
// timer overflow interrupt.
//
// Register map (CPU bus):
//   FF04 DIV  - read counter[15:8]; any write clears the whole 16-bit counter
//   FF05 TIMA - timer counter
//   FF06 TMA  - timer reload value
//   FF07 TAC  - [2] enable, [1:0] rate select; upper bits read as 1
//
// Ports:
//   clk            - system clock, one T-cycle per rising edge
//   reset          - synchronous active-high reset
//   t_cycle        - T-cycle within the current M-cycle; writes commit at 3
//   mem_enable     - bus access request
//   mem_write      - access is a write
//   mem_addr       - bus address
//   mem_data_write - write data
//   mem_data_read  - read data (8'hFF when not selected)
//   mem_selected   - access targets FF04..FF07 (combinational)
//   irq_timer      - one-clock timer interrupt pulse
//
// Optional feature: define TIMER_OVERFLOW_DELAY_EN to get the delayed
// reload (TIMA reads 00 for four clocks, then TMA is loaded with the irq).
// Without it TIMA reloads and irq fires on the same edge as the overflow.
module timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  t_cycle,
  input  logic        mem_enable,
  input  logic        mem_write,
  input  logic [15:0] mem_addr,
  input  logic [7:0]  mem_data_write,
  output logic [7:0]  mem_data_read,
  output logic        mem_selected,
  output logic        irq_timer
);

  localparam logic [15:0] AddrDiv  = 16'hFF04;
  localparam logic [15:0] AddrTima = 16'hFF05;
  localparam logic [15:0] AddrTma  = 16'hFF06;
  localparam logic [15:0] AddrTac  = 16'hFF07;

  logic [15:0] counter_q, counter_d;
  logic [7:0]  tima_q, tima_d;
  logic [7:0]  tma_q, tma_d;
  logic [2:0]  tac_q, tac_d;
  logic        irq_q, irq_d;

`ifdef TIMER_OVERFLOW_DELAY_EN
  typedef enum logic [1:0] {StIdle, StPending, StReload} ovf_state_e;
  ovf_state_e  state_q, state_d;
  logic [1:0]  pend_cnt_q, pend_cnt_d;
`endif

  logic wr_commit;
  logic wr_div, wr_tima, wr_tma, wr_tac;
  logic tick_now, tick_next, tick_fall;

  // Divider tap selected by TAC, gated by the enable bit.
  function automatic logic tick_of(input logic [2:0] tac, input logic [15:0] cnt);
    logic bit_sel;
    unique case (tac[1:0])
      2'b00:   bit_sel = cnt[9];
      2'b01:   bit_sel = cnt[3];
      2'b10:   bit_sel = cnt[5];
      default: bit_sel = cnt[7];
    endcase
    return tac[2] & bit_sel;
  endfunction

  assign mem_selected = mem_enable && (mem_addr >= AddrDiv) && (mem_addr <= AddrTac);
  assign wr_commit    = mem_selected && mem_write && (t_cycle == 2'd3);
  assign wr_div       = wr_commit && (mem_addr == AddrDiv);
  assign wr_tima      = wr_commit && (mem_addr == AddrTima);
  assign wr_tma       = wr_commit && (mem_addr == AddrTma);
  assign wr_tac       = wr_commit && (mem_addr == AddrTac);

  always_comb begin
    mem_data_read = 8'hFF;
    if (mem_selected) begin
      unique case (mem_addr[1:0])
        2'b00:   mem_data_read = counter_q[15:8];
        2'b01:   mem_data_read = tima_q;
        2'b10:   mem_data_read = tma_q;
        default: mem_data_read = {5'b11111, tac_q};
      endcase
    end
  end

  // Increment happens on the edge where tick goes 1->0, comparing the tick
  // seen now with the tick the next register values will produce. This makes
  // DIV and TAC writes that drop the tap count as a falling edge.
  always_comb begin
    counter_d = wr_div ? 16'h0000 : counter_q + 16'd1;
    tma_d     = wr_tma ? mem_data_write : tma_q;
    tac_d     = wr_tac ? mem_data_write[2:0] : tac_q;
    tick_now  = tick_of(tac_q, counter_q);
    tick_next = tick_of(tac_d, counter_d);
    tick_fall = tick_now & ~tick_next;
  end

`ifdef TIMER_OVERFLOW_DELAY_EN
  always_comb begin
    tima_d     = tima_q;
    irq_d      = 1'b0;
    state_d    = state_q;
    pend_cnt_d = pend_cnt_q;
    if (tick_fall) begin
      tima_d = tima_q + 8'd1;
    end
    unique case (state_q)
      StIdle: begin
        if (wr_tima) begin
          tima_d = mem_data_write;
        end else if (tick_fall && (tima_q == 8'hFF)) begin
          // TIMA wraps to 00 and stays there while pending.
          state_d    = StPending;
          pend_cnt_d = 2'd0;
        end
      end
      StPending: begin
        if (wr_tima) begin
          // CPU write cancels the reload and the interrupt.
          tima_d  = mem_data_write;
          state_d = StIdle;
        end else if (pend_cnt_q == 2'd3) begin
          tima_d  = tma_d;
          irq_d   = 1'b1;
          state_d = StReload;
        end else begin
          pend_cnt_d = pend_cnt_q + 2'd1;
        end
      end
      StReload: begin
        // TIMA writes are ignored here; a TMA write in this clock is reloaded.
        tima_d  = tma_d;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end
`else
  always_comb begin
    tima_d = tima_q;
    irq_d  = 1'b0;
    if (wr_tima) begin
      tima_d = mem_data_write;
    end else if (tick_fall) begin
      if (tima_q == 8'hFF) begin
        tima_d = tma_d;
        irq_d  = 1'b1;
      end else begin
        tima_d = tima_q + 8'd1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q  <= 16'h0000;
      tima_q     <= 8'h00;
      tma_q      <= 8'h00;
      tac_q      <= 3'b000;
      irq_q      <= 1'b0;
`ifdef TIMER_OVERFLOW_DELAY_EN
      state_q    <= StIdle;
      pend_cnt_q <= 2'd0;
`endif
    end else begin
      counter_q  <= counter_d;
      tima_q     <= tima_d;
      tma_q      <= tma_d;
      tac_q      <= tac_d;
      irq_q      <= irq_d;
`ifdef TIMER_OVERFLOW_DELAY_EN
      state_q    <= state_d;
      pend_cnt_q <= pend_cnt_d;
`endif
    end
  end

  assign irq_timer = irq_q;

endmodule

// File: tb/tb_timer.sv
// Directed bench for timer. Inputs change and outputs are sampled 1ns (and a
// few ns) after the rising edge. Comments track the free-running counter value.
module tb_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  t_cycle;
  logic        mem_enable;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_write;
  logic [7:0]  mem_data_read;
  logic        mem_selected;
  logic        irq_timer;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  timer dut (
    .clk            (clk),
    .reset          (reset),
    .t_cycle        (t_cycle),
    .mem_enable     (mem_enable),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_data_write (mem_data_write),
    .mem_data_read  (mem_data_read),
    .mem_selected   (mem_selected),
    .irq_timer      (irq_timer)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] data, input logic [1:0] tc);
    mem_enable     = 1'b1;
    mem_write      = 1'b1;
    mem_addr       = addr;
    mem_data_write = data;
    t_cycle        = tc;
    step(1);
    mem_enable     = 1'b0;
    mem_write      = 1'b0;
    t_cycle        = 2'd0;
  endtask

  task automatic chk_rd(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    logic [7:0] d;
    mem_enable = 1'b1;
    mem_write  = 1'b0;
    mem_addr   = addr;
    #1;
    d          = mem_data_read;
    mem_enable = 1'b0;
    check(tag, {8'h00, d}, {8'h00, exp});
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    check(tag, {15'd0, irq_timer}, {15'd0, exp});
  endtask

  // Leaves reset released with counter = 0000.
  task automatic do_reset();
    reset = 1'b1;
    step(3);
    reset = 1'b0;
  endtask

  initial begin
    logic sel;
    logic [7:0] d;
    reset = 1'b1; t_cycle = 2'd0; mem_enable = 1'b0; mem_write = 1'b0;
    mem_addr = 16'h0000; mem_data_write = 8'h00;
    step(3);

    // Reset state
    chk_irq("rst_irq", 1'b0);
    chk_rd("rst_tac", 16'hFF07, 8'hF8);
    chk_rd("rst_tima", 16'hFF05, 8'h00);
    chk_rd("rst_tma", 16'hFF06, 8'h00);
    reset = 1'b0;                                   // counter 0

    // Unmapped address
    mem_enable = 1'b1; mem_addr = 16'hFF10; #1;
    sel = mem_selected; d = mem_data_read; mem_enable = 1'b0;
    check("ff10_sel", {15'd0, sel}, 16'd0);
    check("ff10_data", {8'h00, d}, 16'h00FF);

    // DIV after 0x2FF and 0x300 clocks
    step(16'h2FF);
    chk_rd("div_2ff", 16'hFF04, 8'h02);
    step(1);
    chk_rd("div_300", 16'hFF04, 8'h03);

    // Writes commit only when t_cycle == 3
    wr(16'hFF06, 8'hAB, 2'd1);
    chk_rd("tma_tc1", 16'hFF06, 8'h00);
    wr(16'hFF07, 8'h05, 2'd2);
    chk_rd("tac_tc2", 16'hFF07, 8'hF8);
    wr(16'hFF06, 8'hAB, 2'd3);
    chk_rd("tma_tc3", 16'hFF06, 8'hAB);

    // TAC=5 (bit 3): FE -> FF -> overflow
    do_reset();
    wr(16'hFF07, 8'h05, 2'd3);                      // 1
    wr(16'hFF05, 8'hFE, 2'd3);                      // 2
    wr(16'hFF06, 8'hAB, 2'd3);                      // 3
    step(12);                                       // 15
    chk_rd("tima_c15", 16'hFF05, 8'hFE);
    step(1);                                        // 16
    chk_rd("tima_c16", 16'hFF05, 8'hFF);
    step(15);                                       // 31
    chk_rd("tima_c31", 16'hFF05, 8'hFF);
    chk_irq("irq_c31", 1'b0);
    step(1);                                        // 32
`ifdef TIMER_OVERFLOW_DELAY_EN
    chk_rd("ovf_zero", 16'hFF05, 8'h00);
    chk_irq("ovf_irq0", 1'b0);
    for (int i = 0; i < 3; i++) begin               // 33..35
      step(1);
      chk_rd("pend_zero", 16'hFF05, 8'h00);
      chk_irq("pend_irq", 1'b0);
    end
    step(1);                                        // 36
    chk_rd("reload_tma", 16'hFF05, 8'hAB);
    chk_irq("reload_irq", 1'b1);
    step(1);                                        // 37
`else
    chk_rd("ovf_tma", 16'hFF05, 8'hAB);
    chk_irq("ovf_irq", 1'b1);
    step(5);                                        // 37
`endif
    chk_irq("irq_end", 1'b0);
    chk_rd("tima_after", 16'hFF05, 8'hAB);

    // Overflow, then TIMA write right after
    wr(16'hFF05, 8'hFF, 2'd3);                      // 38
    step(9);                                        // 47
    chk_rd("tima_c47", 16'hFF05, 8'hFF);
    step(1);                                        // 48
`ifdef TIMER_OVERFLOW_DELAY_EN
    chk_rd("ovf2_zero", 16'hFF05, 8'h00);
    chk_irq("ovf2_irq", 1'b0);
`else
    chk_rd("ovf2_tma", 16'hFF05, 8'hAB);
    chk_irq("ovf2_irq", 1'b1);
`endif
    wr(16'hFF05, 8'h33, 2'd3);                      // 49
    chk_rd("cancel_tima", 16'hFF05, 8'h33);
    for (int i = 0; i < 6; i++) begin               // 50..55
      step(1);
      chk_irq("cancel_irq", 1'b0);
    end
    chk_rd("cancel_hold", 16'hFF05, 8'h33);

    // TIMA write coincident with a tick: write wins
    step(8);                                        // 63
    wr(16'hFF05, 8'h50, 2'd3);                      // 64, tick falls here
    chk_rd("wr_vs_tick", 16'hFF05, 8'h50);

    // TAC=4 (bit 9): DIV write with bit 9 high gives one increment
    do_reset();
    wr(16'hFF07, 8'h04, 2'd3);                      // 1
    wr(16'hFF05, 8'h10, 2'd3);                      // 2
    step(510);                                      // 512
    chk_rd("bit9_rise", 16'hFF05, 8'h10);
    wr(16'hFF04, 8'h5A, 2'd3);                      // 0
    chk_rd("div_glitch", 16'hFF05, 8'h11);
    chk_rd("div_clear", 16'hFF04, 8'h00);
    step(255);                                      // 255
    chk_rd("div_255", 16'hFF04, 8'h00);
    step(1);                                        // 256
    chk_rd("div_256", 16'hFF04, 8'h01);
    step(256);                                      // 512
    chk_rd("tima_hold", 16'hFF05, 8'h11);
    wr(16'hFF07, 8'h00, 2'd3);                      // tap drops via TAC write
    chk_rd("tac_glitch", 16'hFF05, 8'h12);

    // Reset in the middle of a pending overflow
    do_reset();
    wr(16'hFF07, 8'h05, 2'd3);                      // 1
    wr(16'hFF05, 8'hFF, 2'd3);                      // 2
    step(14);                                       // 16
    chk_rd("mid_ovf", 16'hFF05, 8'h00);
`ifdef TIMER_OVERFLOW_DELAY_EN
    chk_irq("mid_irq", 1'b0);
`else
    chk_irq("mid_irq", 1'b1);
`endif
    step(1);
    reset = 1'b1;
    step(1);
    chk_rd("rst_mid_tima", 16'hFF05, 8'h00);
    chk_rd("rst_mid_tac", 16'hFF07, 8'hF8);
    chk_irq("rst_mid_irq", 1'b0);
    reset = 1'b0;                                   // 0
    for (int i = 0; i < 8; i++) begin               // 1..8
      step(1);
      chk_irq("post_rst_irq", 1'b0);
    end
    chk_rd("post_rst_tima", 16'hFF05, 8'h00);
    step(247);                                      // 255
    chk_rd("post_rst_div0", 16'hFF04, 8'h00);
    step(1);                                        // 256
    chk_rd("post_rst_div1", 16'hFF04, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 SHALL have port: clk  input  1  system clock, one T-cycle per rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous active-high reset, sampled on rising clk.
REQ-003 SHALL have port: t_cycle  input  2  current T-cycle within the M-cycle (0..3), shared with the CPU.
REQ-004 SHALL have port: mem_enable  input  1  CPU bus access request.
REQ-005 SHALL have port: mem_write  input  1  access is a write (valid when mem_enable).
REQ-006 SHALL have port: mem_addr  input  16  CPU bus address.
REQ-007 SHALL have port: mem_data_write  input  8  CPU write data.
REQ-008 SHALL have port: mem_data_read  output  8  register read data, valid when mem_selected.
REQ-009 SHALL have port: mem_selected  output  1  high when mem_enable and mem_addr is in FF04..FF07 (combinational).
REQ-010 SHALL have port: irq_timer  output  1  one-clock interrupt request pulse.

Function
REQ-011 SHALL keep a 16-bit free-running counter that increments by 1 every clk and wraps FFFF->0000.
REQ-012 SHALL map registers: FF04 DIV = counter[15:8]; FF05 TIMA; FF06 TMA; FF07 TAC[2:0].
REQ-013 SHALL return TAC reads as {5'b11111, TAC[2:0]}, return other register reads unmodified, and drive 8'hFF on mem_data_read when not selected.
REQ-014 SHALL commit writes only on the rising edge where t_cycle==3, mem_enable==1, mem_write==1 and the address is selected.
REQ-015 SHALL clear the whole 16-bit counter on any DIV write, regardless of data.
REQ-016 SHALL form tick = TAC[2] & counter[sel], with sel per TAC[1:0]: 00->bit 9, 01->bit 3, 10->bit 5, 11->bit 7.
REQ-017 SHALL increment TIMA by one on every 1->0 transition of tick, including transitions caused by DIV writes or TAC writes (falling-edge glitch behaviour).
REQ-018 SHALL, on TIMA increment from FF, wrap TIMA to 00 and enter the overflow state.
REQ-019 SHALL have an overflow state machine with states IDLE, PENDING (4 clocks), RELOAD (1 clock); without a TIMA write: IDLE->PENDING on overflow, PENDING->RELOAD after 4 clocks, RELOAD->IDLE.
REQ-020 SHALL, on entry to RELOAD, load TIMA<=TMA and pulse irq_timer high for exactly one clock.
REQ-021 SHALL cancel reload and irq when TIMA is written during PENDING: TIMA takes the written value and the state returns to IDLE.
REQ-022 SHALL ignore TIMA writes during RELOAD; TMA wins and is loaded.
REQ-023 SHALL load the new TMA value into TIMA when TMA is written in the same clock as RELOAD.
REQ-024 SHALL allow a tick increment coincident with a TIMA write; the write wins.

Reset
REQ-025 SHALL, while reset is high, set counter=0000, TIMA=00, TMA=00, TAC=0, state=IDLE, irq_timer=0.
REQ-026 SHALL abandon any pending overflow when reset asserts mid-operation, with no irq afterwards.
REQ-027 SHALL, in the clock after reset releases, begin counting from 0000 with no spurious tick edge.

Configuration
REQ-028 SHALL, with macro TIMER_OVERFLOW_DELAY_EN defined, implement the PENDING/RELOAD delay per REQ-019..REQ-023.
REQ-029 SHALL, without TIMER_OVERFLOW_DELAY_EN, reload TIMA<=TMA and pulse irq_timer in the same clock as the FF->00 overflow; TIMA never reads 00 from overflow, and REQ-021/REQ-022 do not apply.

Verification
REQ-030 SHALL verify: reset, TAC=5 (bit 3), TIMA=FE, TMA=AB -> TIMA reaches FF after 16 clks; on the next overflow (delay build) TIMA reads 00 for 4 clks, then AB with one irq pulse.
REQ-031 SHALL verify: overflow, then CPU writes TIMA=33 in PENDING -> TIMA=33, no irq, TMA not loaded.
REQ-032 SHALL verify: TAC=4, run until counter[9]=1, write DIV -> counter=0000, TIMA increments by exactly 1.
REQ-033 SHALL verify: read FF07 after reset -> F8; read FF04 after 0x0300 clks -> 03; read FF10 -> mem_selected=0, data FF.
REQ-034 SHALL verify: write with t_cycle!=3 -> no register change; the same write with t_cycle==3 -> committed.
REQ-035 SHALL verify: reset asserted during PENDING -> TIMA=00, irq_timer stays 0 through 8 clks after release.
